// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
//   arb_state_e : lock FSM states (IDLE, LOCKED, YIELD)
//   PORT_C/D    : port indices, also the encoding of the round-robin "last granted" bit
//   cnt_w()     : burst counter width for a given MAX_BURST (0 = unlimited)
// Optional feature macro: ARB_ROUND_ROBIN_EN (used by mem_arb_lock_fsm).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    YIELD  = 2'd2
  } arb_state_e;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Unlimited bursts still need a counter; it simply saturates at all-ones.
  function automatic int cnt_w(input int max_burst);
    if (max_burst == 0) return 8;
    return (max_burst < 2) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mem_arb_lock_fsm.sv
// Lock/priority FSM of the arbiter: owns state, burst counter and (optionally)
// the round-robin bit, and turns the registered priority into per-cycle grants.
// Ports:
//   clock, reset      : clock, synchronous active-low reset
//   c_req, d_req      : port requests
//   d_lock            : DMA burst lock request
//   c_gnt, d_gnt      : combinational grants, at most one high, 0 during reset
// Macro ARB_ROUND_ROBIN_EN: IDLE alternates between ports on conflict instead
// of fixed C priority.
module mem_arb_lock_fsm
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic c_req,
  input  logic d_req,
  input  logic d_lock,
  output logic c_gnt,
  output logic d_gnt
);

  localparam int CW = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX = (MAX_BURST == 0) ? {CW{1'b1}} : CW'(MAX_BURST);

  arb_state_e    state, state_n;
  logic [CW-1:0] burst_cnt, cnt_n;
  logic          prio_d, prio_n;   // 1: D wins a conflict this cycle
`ifdef ARB_ROUND_ROBIN_EN
  logic          rr_last, rr_n;
`endif

  // Priority is registered (Moore); only the req qualification is combinational.
  assign c_gnt = reset & c_req & ~(d_req & prio_d);
  assign d_gnt = reset & d_req & ~(c_req & ~prio_d);

  always_comb begin
    state_n = state;
    cnt_n   = burst_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    rr_n = rr_last;
    if (c_gnt)      rr_n = PORT_C;
    else if (d_gnt) rr_n = PORT_D;
`endif
    unique case (state)
      IDLE: begin
        if (d_gnt && d_lock) begin
          state_n = LOCKED;
          cnt_n   = CW'(1);
        end
      end
      LOCKED: begin
        if (!d_lock || !d_req) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (d_gnt && burst_cnt != CNT_MAX) begin
          cnt_n = burst_cnt + 1'b1;
        end
      end
      YIELD: begin
        state_n = d_lock ? LOCKED : IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    // Burst budget used up while C waits: hand C exactly one slot. The check
    // uses the post-grant count so C gets the slot right after grant MAX_BURST.
    if (MAX_BURST != 0 && state_n == LOCKED && state != YIELD &&
        cnt_n == CNT_MAX && c_req) begin
      state_n = YIELD;
      cnt_n   = '0;
    end
    unique case (state_n)
      LOCKED:  prio_n = 1'b1;
      YIELD:   prio_n = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      default: prio_n = (rr_n == PORT_C);
`else
      default: prio_n = 1'b0;
`endif
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last   <= PORT_C;
      prio_d    <= 1'b1;     // rr_last=C, so D wins the first conflict
`else
      prio_d    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      burst_cnt <= cnt_n;
      prio_d    <= prio_n;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last   <= rr_n;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port data RAM between CPU (port C) and DMA (port D).
// Per-cycle req/gnt, 1-cycle read return routed to the port that issued the read,
// locked DMA bursts with bounded CPU starvation (MAX_BURST, 0 = unlimited).
// Ports:
//   clock, reset                      : clock, synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata         : CPU request, held stable until c_gnt
//   c_gnt, c_rvalid, c_rdata          : CPU grant (comb), read return
//   d_req/d_we/d_addr/d_wdata/d_lock  : DMA request and burst lock
//   d_gnt, d_rvalid, d_rdata          : DMA grant (comb), read return
//   ram_write_en/ram_address/ram_data_i : to RAM; ram_data_o from RAM (1-cycle)
// Macro ARB_ROUND_ROBIN_EN: round-robin instead of fixed C priority in IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          ram_write_en,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_i,
  input  logic [DW-1:0] ram_data_o
);

  logic [1:0] rv_q;   // read-return valid, indexed by PORT_C/PORT_D

  mem_arb_lock_fsm #(.MAX_BURST(MAX_BURST)) u_lock (
    .clock  (clock),
    .reset  (reset),
    .c_req  (c_req),
    .d_req  (d_req),
    .d_lock (d_lock),
    .c_gnt  (c_gnt),
    .d_gnt  (d_gnt)
  );

  always_comb begin
    ram_write_en = 1'b0;
    ram_address  = '0;
    ram_data_i   = '0;
    if (c_gnt) begin
      ram_write_en = c_we;
      ram_address  = c_addr;
      ram_data_i   = c_wdata;
    end else if (d_gnt) begin
      ram_write_en = d_we;
      ram_address  = d_addr;
      ram_data_i   = d_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rv_q <= '0;
    end else begin
      rv_q[PORT_C] <= c_gnt & ~c_we;
      rv_q[PORT_D] <= d_gnt & ~d_we;
    end
  end

  // A read granted just before reset would otherwise surface during the reset
  // cycle; qualifying with reset drops it.
  assign c_rvalid = rv_q[PORT_C] & reset;
  assign d_rvalid = rv_q[PORT_D] & reset;
  assign c_rdata  = ram_data_o;
  assign d_rdata  = ram_data_o;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, MAXB = 8;

  logic clock = 1'b0, reset = 1'b0;
  logic c_req = 0, c_we = 0, d_req = 0, d_we = 0, d_lock = 0;
  logic [AW-1:0] c_addr = '0, d_addr = '0;
  logic [DW-1:0] c_wdata = '0, d_wdata = '0;
  logic c_gnt, c_rvalid, d_gnt, d_rvalid, ram_write_en;
  logic [DW-1:0] c_rdata, d_rdata, ram_data_i;
  logic [DW-1:0] ram_data_o = '0;
  logic [AW-1:0] ram_address;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_write_en(ram_write_en), .ram_address(ram_address),
    .ram_data_i(ram_data_i), .ram_data_o(ram_data_o)
  );

  // Environment RAM: 256 words, registered read, cleared while reset is low.
  logic [DW-1:0] ram [256];
  always @(posedge clock) begin
    if (!reset) begin
      foreach (ram[i]) ram[i] <= '0;
    end else begin
      if (ram_write_en) ram[int'(ram_address & 32'hFF)] <= ram_data_i;
      ram_data_o <= ram[int'(ram_address & 32'hFF)];
    end
  end

  int n_assert = 0, n_fail = 0;

  // Reference model: who may win, derived from lock/burst rules.
  bit m_locked, m_yield, m_rr_d;
  int m_run;
  logic [DW-1:0] shadow [256];
  bit exp_crv, exp_drv;
  logic [DW-1:0] exp_cdata, exp_ddata;
  // Sampled DUT activity for directed checks.
  bit a_cg, a_dg, a_crv, a_drv;
  logic [DW-1:0] a_crd;

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a & 32'hFF);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already applied after negedge; check, advance model, wait.
  task automatic tick();
    bit pd, eg_c, eg_d;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    #1;
    if (m_yield) pd = 0;
    else if (m_locked) pd = 1;
    else begin
`ifdef ARB_ROUND_ROBIN_EN
      pd = !m_rr_d;
`else
      pd = 0;
`endif
    end
    eg_c = reset && c_req && !(d_req && pd);
    eg_d = reset && d_req && !(c_req && !pd);
    ea = eg_c ? c_addr : (eg_d ? d_addr : '0);
    ed = eg_c ? c_wdata : (eg_d ? d_wdata : '0);
    check("c_gnt", c_gnt, eg_c);
    check("d_gnt", d_gnt, eg_d);
    check("ram_write_en", ram_write_en, (eg_c && c_we) || (eg_d && d_we));
    check("ram_address", ram_address, ea);
    check("ram_data_i", ram_data_i, ed);
    check("c_rvalid", c_rvalid, exp_crv && reset);
    check("d_rvalid", d_rvalid, exp_drv && reset);
    if (exp_crv && reset) check("c_rdata", c_rdata, exp_cdata);
    if (exp_drv && reset) check("d_rdata", d_rdata, exp_ddata);
    a_cg = c_gnt; a_dg = d_gnt; a_crv = c_rvalid; a_drv = d_rvalid; a_crd = c_rdata;

    if (!reset) begin
      m_locked = 0; m_yield = 0; m_run = 0; m_rr_d = 0;
      exp_crv = 0; exp_drv = 0;
      foreach (shadow[i]) shadow[i] = '0;
    end else begin
      exp_crv = eg_c && !c_we;  exp_cdata = shadow[idx(c_addr)];
      exp_drv = eg_d && !d_we;  exp_ddata = shadow[idx(d_addr)];
      if (eg_c && c_we) shadow[idx(c_addr)] = c_wdata;
      if (eg_d && d_we) shadow[idx(d_addr)] = d_wdata;
      if (m_yield) begin
        m_yield = 0; m_locked = d_lock; m_run = 0;
      end else if (m_locked && (!d_lock || !d_req)) begin
        m_locked = 0; m_run = 0;
      end else begin
        if (eg_d && (m_locked || d_lock)) begin
          m_locked = 1;
          if (MAXB == 0 || m_run < MAXB) m_run++;
        end
        if (m_locked && MAXB != 0 && m_run == MAXB && c_req) begin
          m_yield = 1; m_locked = 0; m_run = 0;
        end
      end
      if (eg_c || eg_d) m_rr_d = eg_d;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int nd, nc_seen, k;
    int c_at [2];
    bit prev;
    @(negedge clock);

    // T1: reset with both requesting, then release
    reset = 0; c_req = 1; d_req = 1; c_addr = 0; d_addr = 4;
    tick(); tick();
    reset = 1;
    tick();
`ifndef ARB_ROUND_ROBIN_EN
    check("t1_c_first", a_cg, 1);
`else
    check("t1_d_first_rr", a_dg, 1);
`endif
    if (a_cg) c_req = 0; else d_req = 0;
    tick();
    c_req = 0; d_req = 0;
    tick();

    // T2: C write then read back
    c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
    tick();
    c_we = 0;
    tick();
    c_req = 0;
    tick();
    check("t2_c_rvalid", a_crv, 1);
    check("t2_c_rdata", a_crd, 32'hDEADBEEF);
    check("t2_d_rvalid", a_drv, 0);

    // T3: simultaneous reads in IDLE
    c_req = 1; d_req = 1; c_addr = 4; d_addr = 8;
    tick();
`ifndef ARB_ROUND_ROBIN_EN
    check("t3_c_first", a_cg, 1);
`endif
    if (a_cg) c_req = 0; else d_req = 0;
    tick();
    c_req = 0; d_req = 0;
    tick();
`ifndef ARB_ROUND_ROBIN_EN
    check("t3_d_rvalid_cyc2", a_drv, 1);
`endif

    // T4: locked D burst of 20 reads with C held
    d_req = 1; d_lock = 1; d_we = 0; d_addr = 32'h40;
    tick();
    nd = a_dg ? 1 : 0;
    c_req = 1; c_we = 0; c_addr = 32'h20;
    nc_seen = 0; k = 0; c_at[0] = -1; c_at[1] = -1;
    while (nd < 20 && k < 60) begin
      if (a_dg) d_addr += 4;
      tick(); k++;
      if (a_dg) nd++;
      if (a_cg) begin
        if (nc_seen < 2) c_at[nc_seen] = nd;
        nc_seen++;
        c_addr += 4;
      end
    end
    check("t4_d_grants", nd, 20);
    check("t4_c_after_8", c_at[0], 8);
    check("t4_c_after_16", c_at[1], 16);
    c_req = 0; d_req = 0; d_lock = 0;
    tick();

`ifdef ARB_ROUND_ROBIN_EN
    // T5: round-robin alternation
    c_req = 1; d_req = 1; c_addr = 32'h80; d_addr = 32'hC0;
    tick();
    prev = a_cg;
    for (int i = 0; i < 8; i++) begin
      if (a_cg) c_addr += 4;
      if (a_dg) d_addr += 4;
      tick();
      check("t5_alternate", a_cg, !prev);
      prev = a_cg;
    end
    c_req = 0; d_req = 0;
    tick();
`endif

    // T6: reset right after a D read grant drops the return
    d_req = 1; d_we = 0; d_addr = 32'h10;
    tick();
    reset = 0; d_req = 0;
    tick();
    check("t6_d_rvalid_dropped", a_drv, 0);
    reset = 1; c_req = 1; d_req = 1; c_addr = 0; d_addr = 4;
    tick();
    check("t6_d_rvalid_after", a_drv, 0);
`ifndef ARB_ROUND_ROBIN_EN
    check("t6_idle_c_prio", a_cg, 1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if (a_cg || !c_req) begin
        c_req = ($urandom % 4) != 0; c_we = $urandom % 2;
        c_addr = $urandom % 256; c_wdata = $urandom;
      end
      if (a_dg || !d_req) begin
        d_req = ($urandom % 4) != 0; d_we = $urandom % 2;
        d_addr = $urandom % 256; d_wdata = $urandom;
      end
      if (($urandom % 12) == 0) d_lock = !d_lock;
      reset = ($urandom % 150) != 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
